// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if
//   Handshake bundle for the InvSubBytes sequencer.
//   Input side : in_valid / in_ready / in_data  (128-bit AES state)
//   Output side: out_valid / out_ready / out_data (128-bit substituted state)
//   master: producer/consumer side (testbench or surrounding round logic)
//   slave : the sequencer itself
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq
//   Applies AES InvSubBytes to a 128-bit state by time-multiplexing LANES
//   inverse S-boxes over the 16 state bytes (N = 16/LANES cycles per state).
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    inv_sub_bytes_seq_if.slave: in_valid/in_ready/in_data,
//            out_valid/out_ready/out_data. Byte k = data[127-8k -: 8],
//            column-major (row = k mod 4, column = k / 4).
//     busy   high while a state is in SUB or DONE
//
//   Parameter LANES: 1, 2, 4, 8 or 16.
//   Optional macro INV_SUB_SHIFTROWS_EN: folds InvShiftRows into the output
//   wiring (out byte r+4c = substituted byte r+4((c-r) mod 4)).
//
//   state | meaning
//   IDLE  | waiting for a state; in_ready high
//   SUB   | LANES bytes substituted per cycle, cnt selects the byte group
//   DONE  | result presented on out_data until out_ready
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  inv_sub_bytes_seq_if.slave  bus,
  output logic                busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   res_q, res_d;
  logic [127:0]   sub_work;
  logic           in_ready_c;

  // Result wiring: identity, or InvShiftRows folded in as a pure byte permutation.
  function automatic logic [127:0] fold_out(input logic [127:0] s);
    logic [127:0] o;
    o = s;
`ifdef INV_SUB_SHIFTROWS_EN
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
`endif
    return o;
  endfunction

  // Byte group selected by cnt is substituted in place; other bytes pass through.
  always_comb begin
    sub_work = work_q;
    for (int i = 0; i < LANES; i++) begin
      sub_work[127 - 8*(int'(cnt_q)*LANES + i) -: 8] =
        INV_SBOX[work_q[127 - 8*(int'(cnt_q)*LANES + i) -: 8]];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    res_d      = res_q;
    in_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d = sub_work;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          res_d   = fold_out(sub_work);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Only state where in_ready follows out_ready combinationally.
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            work_d  = bus.in_data;
            cnt_d   = '0;
            state_d = SUB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_c & rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = res_q;
  assign busy          = (state_q == SUB) || (state_q == DONE);

endmodule
